mac_result_serializer: RTL and testbench
========================================

// Module: mac_result_serializer
// PURPOSE
//   Downstream of mac_module: captures one DATA_WIDTH-bit product (data_p) on a request toggle and
//   streams it as bytes into uart_core's transmitter, one byte per tx_start_transmission toggle,
//   pacing on tx_busy. Sends the full 48-bit accumulator to the host instead of only the low byte.
// PARAMETERS
//   DATA_WIDTH   48    product width; must be a multiple of 8 (elaboration error otherwise)
//   LSB_FIRST    1     1: byte 0 = data[7:0]; 0: byte 0 = data[DATA_WIDTH-1 -: 8]
//   HEADER_EN    0     1: prepend HEADER_BYTE to every frame
//   HEADER_BYTE  8'hA5 frame header value
//   GAP_CYCLES   2     cycles tx_busy is ignored after each start toggle (range 1..15)
// PORTS
//   clk                    in   1           system clock, all logic on posedge
//   reset                  in   1           asynchronous, active-low (0 = reset asserted)
//   send_toggle            in   1           any change of level requests one frame of data_p
//   data_p                 in   DATA_WIDTH  product from mac_module; sampled on accepted request
//   tx_busy                in   1           uart_core transmitter busy
//   tx_data_in             out  8           byte presented to uart_core
//   tx_start_transmission  out  1           toggles once per byte to start transmission
//   busy                   out  1           1 from request acceptance until last byte done
//   done_toggle            out  1           toggles once when a frame completes
//   overrun                out  1           sticky: request arrived while busy; cleared by reset only
// BEHAVIOUR
//   Reset (reset==0, async): all outputs 0, state IDLE, toggle_q 0, shadow 0, byte_idx 0, gap_cnt 0.
//   NBYTES = DATA_WIDTH/8 + HEADER_EN; byte_idx width = clog2(NBYTES+1).
//   Request detect: req = send_toggle ^ toggle_q; toggle_q <= send_toggle every cycle (no reset-exit edge).
//   FSM states IDLE, SEND, GAP, WAIT_TX:
//   IDLE:    on req -> shadow <= data_p, byte_idx <= 0, busy <= 1, -> SEND. else hold.
//   SEND:    tx_data_in <= byte(byte_idx); tx_start_transmission <= ~tx_start_transmission;
//            gap_cnt <= GAP_CYCLES-1; -> GAP. (tx_data_in and toggle change in the same edge.)
//   GAP:     if gap_cnt==0 -> WAIT_TX else gap_cnt <= gap_cnt-1. tx_busy not examined.
//   WAIT_TX: wait for tx_busy==0. Then if byte_idx==NBYTES-1: busy <= 0, done_toggle flips,
//            -> IDLE; else byte_idx <= byte_idx+1, -> SEND.
//   byte(i): HEADER_EN && i==0 -> HEADER_BYTE; else data index j = i-HEADER_EN,
//            LSB_FIRST ? shadow[8j +: 8] : shadow[DATA_WIDTH-8-8j +: 8].
//   Latency: request edge seen at edge k -> first start toggle at edge k+1; per byte
//            = 1 (SEND) + GAP_CYCLES + cycles until tx_busy low.
//   tx_data_in holds its last byte between frames; never changes while awaiting tx_busy.
//   Request while busy (any state but IDLE): dropped, overrun <= 1, current frame unaffected,
//            shadow unchanged. Request on the same edge busy clears: also dropped + overrun.
//   data_p changes after capture have no effect on the frame in flight.
//   tx_busy stuck high: FSM waits indefinitely in WAIT_TX (no timeout); busy stays 1.
//   Reset mid-frame: immediate return to reset state; partially sent frame abandoned;
//            no further toggles until a new request after reset release.
// TESTING
//   1 Reset: hold reset=0 with toggling inputs -> all outputs 0; release, no send_toggle
//     change -> no tx_start_transmission activity for 100 cycles.
//   2 data_p=48'h0123456789AB, send_toggle flip, uart model busy 10 cycles per byte
//     -> bytes AB,89,67,45,23,01 in order, 6 start toggles, done_toggle flips once, busy low.
//   3 HEADER_EN=1, LSB_FIRST=0, same data -> bytes A5,01,23,45,67,89,AB; 7 toggles.
//   4 Second send_toggle flip during byte 3 -> overrun=1 and stays 1; frame completes with
//     6 bytes of original data; no second frame.
//   5 tx_busy held high 500 cycles after byte 0 -> no further toggles, tx_data_in stable;
//     drop tx_busy -> remaining 5 bytes sent normally.
//   6 Assert reset during byte 2 -> outputs 0 asynchronously; release, new request with
//     data_p=48'hFFFF_0000_00FF -> complete fresh 6-byte frame FF,00,00,00,FF,FF.

Source files
------------

// File: rtl/mac_result_serializer.sv
// mac_result_serializer: captures one DATA_WIDTH-bit product from mac_module on a
// request toggle and feeds it byte by byte into uart_core's transmitter, pacing on
// tx_busy. Each byte is started by one toggle of tx_start_transmission.
//
// Handshake: a request is any level change of send_toggle. It is accepted only in
// IDLE. A request arriving in any other state is dropped and sets the sticky overrun
// flag. Downstream, a byte is launched by toggling tx_start_transmission, with
// tx_data_in updated on the same edge. tx_busy is then ignored for GAP_CYCLES cycles,
// which gives the UART time to raise it. After that the next byte waits until tx_busy
// is low.
module mac_result_serializer #(
  parameter int         DATA_WIDTH  = 48,
  parameter bit         LSB_FIRST   = 1'b1,
  parameter bit         HEADER_EN   = 1'b0,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_toggle,
  input  logic [DATA_WIDTH-1:0] data_p,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data_in,
  output logic                  tx_start_transmission,
  output logic                  busy,
  output logic                  done_toggle,
  output logic                  overrun,
  output logic [1:0]            fsm_state
);

  localparam int DBYTES = DATA_WIDTH / 8;
  localparam int NBYTES = DBYTES + (HEADER_EN ? 1 : 0);
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] HDR_OFS  = HEADER_EN ? IDX_W'(1) : '0;
  localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES - 1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("mac_result_serializer: DATA_WIDTH must be a positive multiple of 8");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("mac_result_serializer: GAP_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    GAP     = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

  state_t                state;
  logic                  toggle_q;
  logic [DATA_WIDTH-1:0] shadow;
  logic [IDX_W-1:0]      byte_idx;
  logic [IDX_W-1:0]      data_idx;
  logic [3:0]            gap_cnt;
  logic                  req;
  logic [7:0]            data_bytes [DBYTES];
  logic [7:0]            cur_byte;

  assign req       = send_toggle ^ toggle_q;
  assign fsm_state = state;

  // Slice the captured product into bytes in transmit order.
  always_comb begin
    for (int j = 0; j < DBYTES; j++) begin
      if (LSB_FIRST) data_bytes[j] = shadow[8*j +: 8];
      else           data_bytes[j] = shadow[DATA_WIDTH-8-8*j +: 8];
    end
  end

  // Select the byte for the current index. The header slot underflows data_idx to a
  // value that matches no data byte, so the default of HEADER_BYTE is kept for it.
  always_comb begin
    data_idx = byte_idx - HDR_OFS;
    cur_byte = HEADER_BYTE;
    for (int j = 0; j < DBYTES; j++) begin
      if (data_idx == IDX_W'(j)) cur_byte = data_bytes[j];
    end
  end

  // Request edge detector, frame FSM and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      toggle_q              <= 1'b0;
      shadow                <= '0;
      byte_idx              <= '0;
      gap_cnt               <= '0;
      tx_data_in            <= 8'h00;
      tx_start_transmission <= 1'b0;
      busy                  <= 1'b0;
      done_toggle           <= 1'b0;
      overrun               <= 1'b0;
    end else begin
      toggle_q <= send_toggle;
      // Outside IDLE a request cannot be served. It is dropped and flagged, and the
      // frame in flight is left alone.
      if (req && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            shadow   <= data_p;
            byte_idx <= '0;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          tx_data_in            <= cur_byte;
          tx_start_transmission <= ~tx_start_transmission;
          gap_cnt               <= GAP_LOAD;
          state                 <= GAP;
        end
        GAP: begin
          if (gap_cnt == 4'd0) state <= WAIT_TX;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        WAIT_TX: begin
          if (!tx_busy) begin
            if (byte_idx == LAST_IDX) begin
              busy        <= 1'b0;
              done_toggle <= ~done_toggle;
              state       <= IDLE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Testbench for mac_result_serializer. Two instances share clock and reset:
// dut_a uses the default LSB-first configuration without a header. dut_b has the
// header enabled and sends MSB first. A small UART model behind each instance records
// every launched byte and holds tx_busy high for a fixed number of cycles per byte.
module tb_mac_result_serializer;

  localparam int W        = 48;
  localparam int UART_LEN = 10;

  logic         clk;
  logic         reset;

  logic         send_a, send_b;
  logic [W-1:0] data_a, data_b;
  logic         tx_busy_a, tx_busy_b;
  logic [7:0]   tx_data_a, tx_data_b;
  logic         tx_start_a, tx_start_b;
  logic         busy_a, busy_b;
  logic         done_a, done_b;
  logic         ovr_a, ovr_b;
  logic [1:0]   st_a, st_b;

  logic [7:0]   exp_q[$];
  logic [7:0]   exp_b_q[$];
  logic [7:0]   got_a_q[$];
  logic [7:0]   got_b_q[$];

  int           n_tests = 0;
  int           n_fail  = 0;
  int           toggles_a = 0;
  int           toggles_b = 0;
  logic         hold_a = 1'b0;
  logic         prev_a, prev_b;
  int           bcnt_a, bcnt_b;

  mac_result_serializer #(.DATA_WIDTH(W)) dut_a (
    .clk(clk), .reset(reset), .send_toggle(send_a), .data_p(data_a),
    .tx_busy(tx_busy_a), .tx_data_in(tx_data_a), .tx_start_transmission(tx_start_a),
    .busy(busy_a), .done_toggle(done_a), .overrun(ovr_a), .fsm_state(st_a)
  );

  mac_result_serializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b0), .HEADER_EN(1'b1),
                          .HEADER_BYTE(8'hA5), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .send_toggle(send_b), .data_p(data_b),
    .tx_busy(tx_busy_b), .tx_data_in(tx_data_b), .tx_start_transmission(tx_start_b),
    .busy(busy_b), .done_toggle(done_b), .overrun(ovr_b), .fsm_state(st_b)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model for dut_a. It records each launched byte and then reports busy.
  always @(negedge clk) begin
    if (!reset) begin
      prev_a = 1'b0; bcnt_a = 0; tx_busy_a = 1'b0;
    end else begin
      if (tx_start_a !== prev_a) begin
        prev_a = tx_start_a;
        got_a_q.push_back(tx_data_a);
        toggles_a++;
        bcnt_a = UART_LEN;
      end else if (bcnt_a > 0) bcnt_a--;
      tx_busy_a = (bcnt_a != 0) || hold_a;
    end
  end

  // UART model for dut_b.
  always @(negedge clk) begin
    if (!reset) begin
      prev_b = 1'b0; bcnt_b = 0; tx_busy_b = 1'b0;
    end else begin
      if (tx_start_b !== prev_b) begin
        prev_b = tx_start_b;
        got_b_q.push_back(tx_data_b);
        toggles_b++;
        bcnt_b = UART_LEN;
      end else if (bcnt_b > 0) bcnt_b--;
      tx_busy_b = (bcnt_b != 0);
    end
  end

  // Wait for done_toggle of dut_a to change, bounded by a cycle budget.
  task automatic wait_done_a(input int budget, output bit ok);
    logic start;
    start = done_a;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_a !== start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done_b(input int budget, output bit ok);
    logic start;
    start = done_b;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_b !== start) begin ok = 1'b1; break; end
    end
  endtask

  // Wait until the UART model of dut_a has seen a given number of start toggles.
  task automatic wait_toggles_a(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (toggles_a >= target) begin ok = 1'b1; break; end
    end
  endtask

  // Push the expected LSB-first byte sequence of one product onto exp_q.
  task automatic push_lsb(input logic [W-1:0] d);
    for (int j = 0; j < W/8; j++) exp_q.push_back(d[8*j +: 8]);
  endtask

  task automatic test_reset();
    int t0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      send_a = ~send_a; send_b = ~send_b;
      data_a = {$urandom, $urandom_range(0, 65535)};
      data_b = {$urandom, $urandom_range(0, 65535)};
      hold_a = ~hold_a;
    end
    @(negedge clk);
    send_a = 1'b0; send_b = 1'b0; hold_a = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({tx_data_a, tx_start_a, busy_a, done_a, ovr_a, st_a} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_a: outputs %h, expected 0",
               {tx_data_a, tx_start_a, busy_a, done_a, ovr_a, st_a});
    end
    n_tests++;
    if ({tx_data_b, tx_start_b, busy_b, done_b, ovr_b, st_b} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_b: outputs %h, expected 0",
               {tx_data_b, tx_start_b, busy_b, done_b, ovr_b, st_b});
    end
    @(negedge clk);
    reset = 1'b1;
    t0 = toggles_a + toggles_b;
    repeat (100) @(posedge clk);
    #1;
    n_tests++;
    if (toggles_a + toggles_b != t0 || tx_start_a !== 1'b0 || tx_start_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: toggles %0d start %b/%b, expected %0d and 0/0",
               toggles_a + toggles_b, tx_start_a, tx_start_b, t0);
    end
  endtask

  task automatic test_lsb_frame();
    bit ok;
    int t0;
    logic d0, s0;
    logic [7:0] e, g;
    data_a = 48'h0123456789AB;
    push_lsb(data_a);
    t0 = toggles_a;
    d0 = done_a;
    s0 = tx_start_a;
    @(negedge clk);
    send_a = ~send_a;
    // The edge that sees the request only accepts it. The following edge launches byte 0.
    @(posedge clk); #1;
    n_tests++;
    if (busy_a !== 1'b1 || tx_start_a !== s0) begin
      n_fail++;
      $display("FAIL lsb_accept: busy %b start %b, expected 1 and %b", busy_a, tx_start_a, s0);
    end
    @(posedge clk); #1;
    n_tests++;
    if (tx_start_a !== ~s0 || tx_data_a !== 8'hAB) begin
      n_fail++;
      $display("FAIL lsb_first_byte: start %b data %h, expected %b and ab", tx_start_a, tx_data_a, ~s0);
    end
    wait_done_a(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL lsb_done_timeout: done %b, expected flip", done_a); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_a_q.size() == 0) begin
        n_fail++; $display("FAIL lsb_byte: missing, expected %h", e);
      end else begin
        g = got_a_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL lsb_byte: got %h, expected %h", g, e); end
      end
    end
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (toggles_a - t0 != 6 || done_a !== ~d0 || busy_a !== 1'b0 || got_a_q.size() != 0) begin
      n_fail++;
      $display("FAIL lsb_summary: toggles %0d done %b busy %b extra %0d, expected 6 %b 0 0",
               toggles_a - t0, done_a, busy_a, got_a_q.size(), ~d0);
    end
  endtask

  task automatic test_header_msb();
    bit ok;
    int t0;
    logic [7:0] e, g;
    data_b = 48'h0123456789AB;
    exp_b_q.push_back(8'hA5);
    for (int j = 0; j < W/8; j++) exp_b_q.push_back(data_b[W-8-8*j +: 8]);
    t0 = toggles_b;
    @(negedge clk);
    send_b = ~send_b;
    wait_done_b(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL hdr_done_timeout: done %b, expected flip", done_b); end
    while (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      n_tests++;
      if (got_b_q.size() == 0) begin
        n_fail++; $display("FAIL hdr_byte: missing, expected %h", e);
      end else begin
        g = got_b_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL hdr_byte: got %h, expected %h", g, e); end
      end
    end
    n_tests++;
    if (toggles_b - t0 != 7 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL hdr_count: toggles %0d busy %b, expected 7 and 0", toggles_b - t0, busy_b);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int t0;
    logic [7:0] e, g;
    data_a = 48'hC0FFEE123456;
    push_lsb(data_a);
    t0 = toggles_a;
    @(negedge clk);
    send_a = ~send_a;
    wait_toggles_a(t0 + 4, 2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ovr_byte3_timeout: toggles %0d, expected %0d", toggles_a - t0, 4); end
    @(negedge clk);
    send_a = ~send_a;
    data_a = 48'hDEADBEEFDEAD;
    @(posedge clk); #1;
    n_tests++;
    if (ovr_a !== 1'b1 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL ovr_set: overrun %b busy %b, expected 1 1", ovr_a, busy_a);
    end
    wait_done_a(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ovr_done_timeout: done %b, expected flip", done_a); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_a_q.size() == 0) begin
        n_fail++; $display("FAIL ovr_byte: missing, expected %h", e);
      end else begin
        g = got_a_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL ovr_byte: got %h, expected %h", g, e); end
      end
    end
    repeat (100) @(posedge clk);
    #1;
    n_tests++;
    if (toggles_a - t0 != 6 || ovr_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_no_second: toggles %0d overrun %b busy %b, expected 6 1 0",
               toggles_a - t0, ovr_a, busy_a);
    end
  endtask

  task automatic test_busy_stuck();
    bit ok;
    int t0;
    logic [7:0] e, g;
    data_a = 48'h112233445566;
    push_lsb(data_a);
    t0 = toggles_a;
    hold_a = 1'b1;
    @(negedge clk);
    send_a = ~send_a;
    wait_toggles_a(t0 + 1, 200, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stuck_first_timeout: toggles %0d, expected 1", toggles_a - t0); end
    repeat (500) @(posedge clk);
    #1;
    n_tests++;
    if (toggles_a - t0 != 1 || tx_data_a !== 8'h66 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_hold: toggles %0d data %h busy %b, expected 1 66 1",
               toggles_a - t0, tx_data_a, busy_a);
    end
    @(negedge clk);
    hold_a = 1'b0;
    wait_done_a(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stuck_done_timeout: done %b, expected flip", done_a); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_a_q.size() == 0) begin
        n_fail++; $display("FAIL stuck_byte: missing, expected %h", e);
      end else begin
        g = got_a_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL stuck_byte: got %h, expected %h", g, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] e, g;
    for (int f = 0; f < 2; f++) begin
      data_a = {$urandom, $urandom_range(0, 65535)};
      push_lsb(data_a);
      @(negedge clk);
      send_a = ~send_a;
      // Changing data_p after capture must not affect the frame in flight.
      @(negedge clk);
      data_a = ~data_a;
      wait_done_a(2000, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL b2b_done_timeout: frame %0d not done", f); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_a_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_byte: missing, expected %h", e);
      end else begin
        g = got_a_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL b2b_byte: got %h, expected %h", g, e); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int t0;
    logic [7:0] e, g;
    data_a = 48'hA1B2C3D4E5F6;
    t0 = toggles_a;
    @(negedge clk);
    send_a = ~send_a;
    wait_toggles_a(t0 + 3, 2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rst_mid_timeout: toggles %0d, expected 3", toggles_a - t0); end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({tx_data_a, tx_start_a, busy_a, done_a, ovr_a, st_a} !== 14'h0) begin
      n_fail++;
      $display("FAIL rst_mid_async: outputs %h, expected 0",
               {tx_data_a, tx_start_a, busy_a, done_a, ovr_a, st_a});
    end
    send_a = 1'b0;
    send_b = 1'b0;
    repeat (3) @(negedge clk);
    got_a_q.delete();
    exp_q.delete();
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (got_a_q.size() != 0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: bytes %0d busy %b, expected 0 0", got_a_q.size(), busy_a);
    end
    data_a = 48'hFFFF000000FF;
    push_lsb(data_a);
    @(negedge clk);
    send_a = 1'b1;
    wait_done_a(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rst_fresh_timeout: done %b, expected flip", done_a); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_a_q.size() == 0) begin
        n_fail++; $display("FAIL rst_fresh_byte: missing, expected %h", e);
      end else begin
        g = got_a_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL rst_fresh_byte: got %h, expected %h", g, e); end
      end
    end
    n_tests++;
    if (got_a_q.size() != 0 || ovr_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fresh_tail: extra %0d overrun %b, expected 0 0", got_a_q.size(), ovr_a);
    end
  endtask

  initial begin
    reset  = 1'b0;
    send_a = 1'b0; send_b = 1'b0;
    data_a = '0;   data_b = '0;
    test_reset();
    test_lsb_frame();
    test_header_msb();
    test_overrun();
    test_busy_stuck();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
